reg_file: RTL and testbench



---
 rtl/mips_pkg.sv | 10 +
 rtl/reg_file.sv | 57 +++++
 tb/tb_reg_file.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and register index type
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file, r0 hardwired zero; REGFILE_BYPASS_EN adds write-to-read bypass
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W    = mips_pkg::DATA_W,
    parameter int REG_COUNT = mips_pkg::REG_COUNT,
    parameter int ADDR_W    = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    // r0 has no storage; index 0 is decoded to zero on the read side
    logic [DATA_W-1:0] regs [1:REG_COUNT-1];

    logic              wr_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    assign wr_en = WE3 && (A3 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[A3] <= WD3;
        end
    end

    assign stored1 = (A1 == '0) ? '0 : regs[A1];
    assign stored2 = (A2 == '0) ? '0 : regs[A2];

`ifdef REGFILE_BYPASS_EN
    // Forward write data to a reader of the same index; wr_en already excludes r0
    logic byp1;
    logic byp2;

    assign byp1 = wr_en && rst_n && (A1 == A3);
    assign byp2 = wr_en && rst_n && (A2 == A3);

    assign RD1 = byp1 ? WD3 : stored1;
    assign RD2 = byp2 ? WD3 : stored2;
`else
    assign RD1 = stored1;
    assign RD2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed table-driven bench for reg_file
module tb_reg_file;
    import mips_pkg::*;

    logic              clk;
    logic              clk_en;
    logic              rst_n;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic              WE3;
    logic [DATA_W-1:0] WD3;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;

    int checks;
    int errors;

    reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WE3   (WE3),
        .WD3   (WD3),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] a3;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_edge(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        WE3 = 1'b1;
        A3  = a;
        WD3 = d;
        @(posedge clk);
        #1;
        WE3 = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] pre_exp;
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        WE3    = 1'b0;
        A1     = '0;
        A2     = '0;
        A3     = '0;
        WD3    = '0;

        vecs[0] = '{1'b1, 5'd8,  32'h12345678, 5'd8,  5'd8,  32'h12345678, 32'h12345678};
        vecs[1] = '{1'b1, 5'd9,  32'h0000FFFF, 5'd8,  5'd9,  32'h12345678, 32'h0000FFFF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd9,  32'h00000000, 32'h0000FFFF};
        vecs[3] = '{1'b0, 5'd10, 32'hAAAAAAAA, 5'd10, 5'd8,  32'h00000000, 32'h12345678};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'hCAFEF00D, 32'h00000000};
        vecs[5] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd31, 32'h11111111, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 5'd3,  32'h00000001, 5'd3,  5'd0,  32'h00000001, 32'h00000000};

        // reset held with the clock stopped: every index reads zero
        for (int i = 0; i < REG_COUNT; i++) begin
            A1 = ADDR_W'(i);
            A2 = ADDR_W'(REG_COUNT - 1 - i);
            #1;
            check($sformatf("reset_rd1_%0d", i), RD1, '0);
            check($sformatf("reset_rd2_%0d", i), RD2, '0);
        end

        rst_n  = 1'b1;
        #2;
        clk_en = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            WE3 = vecs[v].we;
            A3  = vecs[v].a3;
            WD3 = vecs[v].wd;
            A1  = vecs[v].a1;
            A2  = vecs[v].a2;
            @(posedge clk);
            #1;
            WE3 = 1'b0;
            #1;
            check($sformatf("vec%0d_rd1", v), RD1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), RD2, vecs[v].exp2);
        end

        // same-cycle read of the register being written (r3 holds 1)
        @(negedge clk);
        WE3 = 1'b1;
        A3  = 5'd3;
        WD3 = 32'h00000002;
        A1  = 5'd3;
        A2  = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        pre_exp = 32'h00000002;
`else
        pre_exp = 32'h00000001;
`endif
        check("same_cycle_pre_rd1", RD1, pre_exp);
        check("same_cycle_pre_rd2", RD2, pre_exp);
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        #1;
        check("same_cycle_post_rd1", RD1, 32'h00000002);

        // index 0 never bypasses
        @(negedge clk);
        WE3 = 1'b1;
        A3  = 5'd0;
        WD3 = 32'h00000077;
        A1  = 5'd0;
        #1;
        check("r0_no_bypass", RD1, '0);
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        #1;
        check("r0_after_write", RD1, '0);

        // asynchronous reset between edges clears a live register
        write_edge(5'd5, 32'hDEADBEEF);
        A1 = 5'd5;
        A2 = 5'd8;
        #1;
        check("r5_written", RD1, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async_reset_rd1", RD1, '0);
        check("async_reset_rd2", RD2, '0);

        // write coinciding with reset is discarded
        WE3 = 1'b1;
        A3  = 5'd4;
        WD3 = 32'h00000055;
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        A1 = 5'd4;
        A2 = 5'd5;
        #1;
        check("reset_wins_r4", RD1, '0);
        check("reset_cleared_r5", RD2, '0);

        // first edge after release accepts a write
        write_edge(5'd4, 32'h00000066);
        A1 = 5'd4;
        #1;
        check("post_release_write", RD1, 32'h00000066);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
